// File: rtl/pio_bus_sequencer.sv
// Sequences single-word reads and writes onto an Avalon-style PIO slave, caching the
// port direction so that repeated same-type commands skip the direction write.
module pio_bus_sequencer #(
    parameter int unsigned TURNAROUND = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        busy,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic [31:0] pio_readdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_DIR_WR, S_TURN, S_DATA_WR, S_RD_ADDR, S_RD_CAP, S_RSP
    } state_t;

    localparam logic [3:0] TURN_LOAD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;
    localparam logic [31:0] DIR_OUT = 32'hFFFF_FFFF;
    localparam logic [31:0] DIR_IN  = 32'h0000_0000;

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] dir_q, dir_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            dir_q   <= DIR_IN;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Command latch needs no reset: it is only consumed after an accept.
    always_ff @(posedge clk) begin
        wr_q    <= wr_d;
        wdata_q <= wdata_d;
    end

    always_comb begin
        state_d        = state_q;
        wr_d           = wr_q;
        wdata_d        = wdata_q;
        dir_d          = dir_q;
        cnt_d          = cnt_q;
        rdata_d        = rdata_q;
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_address    = 2'd0;
        pio_writedata  = 32'd0;

        case (state_q)
            S_IDLE: begin
                cmd_ready = !reset;
                if (cmd_valid && !reset) begin
                    wr_d    = cmd_write;
                    wdata_d = cmd_wdata;
                    if (cmd_write) begin
                        state_d = (dir_q != DIR_OUT) ? S_DIR_WR : S_DATA_WR;
                    end else begin
                        state_d = (dir_q != DIR_IN) ? S_DIR_WR : S_RD_ADDR;
                    end
                end
            end
            S_DIR_WR: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_address    = 2'd1;
                pio_writedata  = wr_q ? DIR_OUT : DIR_IN;
                dir_d          = wr_q ? DIR_OUT : DIR_IN;
                cnt_d          = TURN_LOAD;
                if (wr_q) begin
                    state_d = S_DATA_WR;
                end else begin
                    state_d = (TURNAROUND > 0) ? S_TURN : S_RD_ADDR;
                end
            end
            S_TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RD_ADDR;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DATA_WR: begin
                pio_chipselect = 1'b1;
                pio_write_n    = 1'b0;
                pio_writedata  = wdata_q;
                state_d        = S_IDLE;
            end
            S_RD_ADDR: begin
                pio_chipselect = 1'b1;
                state_d        = S_RD_CAP;
            end
            // Slave registers the read, so data is valid the cycle after RD_ADDR.
            S_RD_CAP: begin
                rdata_d = pio_readdata;
                state_d = S_RSP;
            end
            S_RSP: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign rsp_rdata = rdata_q;

endmodule

// File: doc/pio_bus_sequencer.md
PIO_BUS_SEQUENCER -- requirements
Module: pio_bus_sequencer

Interface
REQ-001 SHALL have parameter TURNAROUND, default 2: idle cycles inserted after switching the port to input before sampling (range 0..15).
REQ-002 SHALL have port clk  in  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  in  1  command request.
REQ-005 SHALL have port cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-006 SHALL have port cmd_write  in  1  1 = drive word onto port, 0 = sample port.
REQ-007 SHALL have port cmd_wdata  in  32  word to drive.
REQ-008 SHALL have port rsp_valid  out  1  one-cycle pulse: read result available.
REQ-009 SHALL have port rsp_rdata  out  32  last sampled word.
REQ-010 SHALL have port busy  out  1  high whenever the FSM is not in IDLE.
REQ-011 SHALL have port pio_address  out  2  to the PIO slave (0 = data, 1 = direction).
REQ-012 SHALL have port pio_chipselect  out  1  to the PIO slave.
REQ-013 SHALL have port pio_write_n  out  1  to the PIO slave, active-low write.
REQ-014 SHALL have port pio_writedata  out  32  to the PIO slave.
REQ-015 SHALL have port pio_readdata  in  32  from the PIO slave; registered there, one-cycle read latency.

Function
REQ-016 SHALL implement FSM states IDLE, DIR_WR, TURN, DATA_WR, RD_ADDR, RD_CAP, RSP, all registered.
REQ-017 SHALL assert cmd_ready only in IDLE; a command is accepted on the edge where cmd_valid && cmd_ready, with cmd_write/cmd_wdata latched then.
REQ-018 SHALL keep a dir_cache register (32 bits) mirroring the last direction value written to the PIO.
REQ-019 Write accepted: to DIR_WR if dir_cache != 32'hFFFFFFFF, else directly to DATA_WR.
REQ-020 Read accepted: to DIR_WR if dir_cache != 0, else directly to RD_ADDR.
REQ-021 DIR_WR (one cycle): pio_chipselect=1, pio_write_n=0, pio_address=1, pio_writedata = all-ones (write) or 0 (read); dir_cache updated to the same value.
REQ-022 From DIR_WR: write -> DATA_WR; read -> TURN if TURNAROUND>0, else RD_ADDR.
REQ-023 TURN: bus idle; a counter loads TURNAROUND-1 on entry and decrements; exit to RD_ADDR when it reaches 0 (exactly TURNAROUND cycles in TURN).
REQ-024 DATA_WR (one cycle): chipselect=1, write_n=0, address=0, writedata = latched word; next state IDLE; writes produce no rsp_valid.
REQ-025 RD_ADDR (one cycle): chipselect=1, write_n=1, address=0; next RD_CAP.
REQ-026 RD_CAP (one cycle): rsp_rdata <= pio_readdata; next RSP.
REQ-027 RSP (one cycle): rsp_valid=1; next IDLE; rsp_rdata held until the next RD_CAP.
REQ-028 In IDLE, TURN, RD_CAP and RSP: pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
REQ-029 Latency from accept edge: write with cached direction, bus write 1 cycle later, ready again 2 cycles later; read with cached direction, rsp_valid 3 cycles later; a direction change adds 1 cycle (write) or 1+TURNAROUND cycles (read).
REQ-030 Back-to-back same-type commands SHALL skip DIR_WR; alternating types SHALL issue DIR_WR every command.
REQ-031 No response back-pressure: rsp_valid is a pulse and SHALL NOT wait for any consumer.

Reset
REQ-032 Reset SHALL force state IDLE, dir_cache=0 (matches PIO direction reset), counter=0, rsp_valid=0, rsp_rdata=0, busy=0, cmd_ready=0 during reset and 1 the cycle after, and pio_* outputs to the REQ-028 idle values.
REQ-033 Reset asserted mid-command SHALL abort it with no further bus cycle and no rsp_valid; a command presented during reset SHALL NOT be accepted.

Verification
REQ-034 After reset, read with pio_readdata model = 32'h1234_5678 -> no DIR_WR, RD_ADDR at +1, rsp_valid at +3 with rsp_rdata=32'h1234_5678.
REQ-035 After reset, write 32'hDEAD_BEEF -> DIR_WR (addr 1, data FFFFFFFF) at +1, DATA_WR (addr 0, data DEADBEEF) at +2, cmd_ready high at +3, no rsp_valid.
REQ-036 Write then read, TURNAROUND=2 -> DIR_WR (data 0) at +1, TURN at +2..+3, RD_ADDR at +4, rsp_valid at +6; repeat with TURNAROUND=0 -> rsp_valid at +4.
REQ-037 Two consecutive writes with cmd_valid held high -> second write has no DIR_WR; exactly three bus writes total.
REQ-038 Reset pulsed during TURN -> no RD_ADDR, no rsp_valid, dir_cache=0; the following read issues no DIR_WR.
REQ-039 cmd_valid high while busy -> cmd_ready=0 and the command is not taken until IDLE; cmd_wdata changes while busy do not alter pio_writedata.
